cv32e40p_debug_entry_tracker: RTL

// - Upstream of the controller debug FSM. Turns external halt requests, single-step completion
//   and sleep-wakeup needs into registered entry qualifiers (debug_req_entry_q, debug_force_wakeup_q).
// - Captures the DCSR cause on each debug entry and tracks debug mode until dret.
// - The controller consumes these outputs to choose between DBG_TAKEN_ID, DBG_TAKEN_IF and DBG_FLUSH.

---
 rtl/cv32e40p_debug_entry_tracker.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cv32e40p_debug_entry_tracker.sv
// Debug entry tracker: synchronises external halt requests and turns halt, single-step and
// sleep-wakeup needs into registered entry qualifiers; records the DCSR cause on entry.
module cv32e40p_debug_entry_tracker #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_HALT  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       debug_req_i,
  input  logic       trigger_match_i,
  input  logic       ebrk_insn_i,
  input  logic       ebrk_force_debug_mode_i,
  input  logic       debug_single_step_i,
  input  logic       id_valid_i,
  input  logic       sleeping_i,
  input  logic       debug_taken_i,
  input  logic       dret_i,
  output logic       debug_req_entry_q_o,
  output logic       debug_force_wakeup_q_o,
  output logic       debug_mode_o,
  output logic [2:0] debug_cause_o
);

  typedef enum logic [1:0] {RUN, WAKEUP, REQ_PEND, HALTED} state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_HALT, SRC_STEP, SRC_RESETHALT} src_e;

  localparam state_e     RESET_STATE = RESET_HALT ? REQ_PEND : RUN;
  localparam src_e       RESET_SRC   = RESET_HALT ? SRC_RESETHALT : SRC_NONE;
  localparam logic [2:0] RESET_CAUSE = RESET_HALT ? 3'd5 : 3'd0;

  // state_q is the FSM state that checkers bind to
  state_e     state_q;
  src_e       src_q;
  logic [2:0] cause_q;
  logic       req_s;
  logic       cause_load;
  logic [2:0] cause_d;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign req_s = debug_req_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= debug_req_i;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign req_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Cause priority: trigger, forced ebreak, then the recorded source of the pending entry.
  always_comb begin
    cause_load = 1'b1;
    cause_d    = cause_q;
    if (trigger_match_i) begin
      cause_d = 3'd2;
    end else if (ebrk_insn_i && ebrk_force_debug_mode_i) begin
      cause_d = 3'd1;
    end else begin
      case (src_q)
        SRC_RESETHALT: cause_d = 3'd5;
        SRC_HALT:      cause_d = 3'd3;
        SRC_STEP:      cause_d = 3'd4;
        default:       cause_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESET_STATE;
      src_q   <= RESET_SRC;
      cause_q <= RESET_CAUSE;
    end else begin
      case (state_q)
        RUN: begin
          if (debug_taken_i) begin
            state_q <= HALTED;
            src_q   <= SRC_NONE;
            if (cause_load) cause_q <= cause_d;
          end else if (req_s && sleeping_i) begin
            state_q <= WAKEUP;
            src_q   <= SRC_HALT;
          end else if (req_s) begin
            state_q <= REQ_PEND;
            src_q   <= SRC_HALT;
          end else if (debug_single_step_i && id_valid_i) begin
            state_q <= REQ_PEND;
            src_q   <= SRC_STEP;
          end
        end
        WAKEUP: begin
          if (debug_taken_i) begin
            state_q <= HALTED;
            src_q   <= SRC_NONE;
            if (cause_load) cause_q <= cause_d;
          end else if (!sleeping_i) begin
            state_q <= REQ_PEND;
            src_q   <= SRC_HALT;
          end
        end
        REQ_PEND: begin
          if (debug_taken_i) begin
            state_q <= HALTED;
            src_q   <= SRC_NONE;
            if (cause_load) cause_q <= cause_d;
          end
        end
        HALTED: begin
          if (dret_i) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign debug_req_entry_q_o    = (state_q == REQ_PEND);
  assign debug_force_wakeup_q_o = (state_q == WAKEUP);
  assign debug_mode_o           = (state_q == HALTED);
  assign debug_cause_o          = cause_q;

endmodule
